// File: rtl/unary_pkg.sv
// Shared definitions for the unary bitstream producer and consumers.
// Holds the default frame length, value-width helper and FSM states.
package unary_pkg;

    localparam int FRAME_LEN_DEF = 16;

    // One headroom bit above the clamp range so over-range loads are visible.
    function automatic int val_w(input int frame_len);
        return $clog2(frame_len + 1) + 1;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/unary_lane_enc.sv
// One unary lane: pending/current value registers, clamp and
// thermometer compare of the bit index against the held value.
module unary_lane_enc
    import unary_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int VAL_W     = val_w(FRAME_LEN),
    parameter int PW        = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [VAL_W-1:0] value,
    input  logic             xfer,
    input  logic             sel_pend,
    input  logic [PW-1:0]    pos,
    output logic             lane_bit,
    output logic             over
);

    localparam logic [VAL_W-1:0] MAX_V = VAL_W'(FRAME_LEN);

    logic [VAL_W-1:0] pend;
    logic [VAL_W-1:0] cur;
    logic [VAL_W-1:0] clamped;
    logic [VAL_W-1:0] src;
    logic [VAL_W-1:0] idx;

    assign over    = value > MAX_V;
    assign clamped = over ? MAX_V : value;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            cur  <= '0;
        end else begin
            if (load) begin
                pend <= clamped;
            end
            if (xfer) begin
                cur <= pend;
            end
        end
    end

    // Bit 0 of a frame started from IDLE comes straight from pend.
    always_comb begin
        src      = sel_pend ? pend : cur;
        idx      = sel_pend ? '0 : VAL_W'(pos);
        lane_bit = idx < src;
    end

endmodule

// File: rtl/unary_stream_gen.sv
// Dual-lane binary-to-unary stream generator with a one-entry
// pending buffer so consecutive frames stream without a gap.
module unary_stream_gen
    import unary_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int VAL_W     = val_w(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [VAL_W-1:0] a_value,
    input  logic [VAL_W-1:0] b_value,
    input  logic             hold,
    output logic             a_bit,
    output logic             b_bit,
    output logic             en_out,
    output logic             frame_last,
    output logic             sat,
    output logic             busy
);

    localparam int PW = $clog2(FRAME_LEN);
    localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_n;
    logic          pend_valid;
    logic          pend_valid_n;

    logic accept;
    logic xfer;
    logic sel_pend;
    logic emit;
    logic last;
    logic a_lane;
    logic b_lane;
    logic a_over;
    logic b_over;

    logic a_bit_n;
    logic b_bit_n;
    logic en_n;
    logic last_n;
    logic sat_n;
    logic busy_n;

    assign load_ready = ~pend_valid;
    assign accept     = load_valid & ~pend_valid;
    assign last       = pos == LAST;

    unary_lane_enc #(
        .FRAME_LEN(FRAME_LEN),
        .VAL_W    (VAL_W),
        .PW       (PW)
    ) u_lane_a (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .value   (a_value),
        .xfer    (xfer),
        .sel_pend(sel_pend),
        .pos     (pos),
        .lane_bit(a_lane),
        .over    (a_over)
    );

    unary_lane_enc #(
        .FRAME_LEN(FRAME_LEN),
        .VAL_W    (VAL_W),
        .PW       (PW)
    ) u_lane_b (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .value   (b_value),
        .xfer    (xfer),
        .sel_pend(sel_pend),
        .pos     (pos),
        .lane_bit(b_lane),
        .over    (b_over)
    );

    always_comb begin
        state_n      = state;
        pos_n        = pos;
        pend_valid_n = pend_valid;
        xfer         = 1'b0;
        sel_pend     = 1'b0;
        emit         = 1'b0;
        if (accept) begin
            pend_valid_n = 1'b1;
        end
        unique case (state)
            IDLE: begin
                // Start emits bit 0 immediately; pos then names the next bit.
                if (pend_valid && !hold) begin
                    xfer         = 1'b1;
                    sel_pend     = 1'b1;
                    emit         = 1'b1;
                    pend_valid_n = 1'b0;
                    pos_n        = PW'(1);
                    state_n      = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    emit = 1'b1;
                    if (last) begin
                        pos_n = '0;
                        if (pend_valid) begin
                            xfer         = 1'b1;
                            pend_valid_n = 1'b0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        pos_n = pos + PW'(1);
                    end
                end
            end
        endcase
        a_bit_n = emit & a_lane;
        b_bit_n = emit & b_lane;
        en_n    = emit;
        last_n  = emit & (state == RUN) & last;
        sat_n   = accept & (a_over | b_over);
        busy_n  = (state_n == RUN) | pend_valid_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pos        <= '0;
            pend_valid <= 1'b0;
            a_bit      <= 1'b0;
            b_bit      <= 1'b0;
            en_out     <= 1'b0;
            frame_last <= 1'b0;
            sat        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            pos        <= pos_n;
            pend_valid <= pend_valid_n;
            a_bit      <= a_bit_n;
            b_bit      <= b_bit_n;
            en_out     <= en_n;
            frame_last <= last_n;
            sat        <= sat_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_unary_stream_gen.sv
// Self-checking bench for unary_stream_gen: directed scenarios plus a
// randomized run checked against a frame-level thermometer model.
module tb_unary_stream_gen;
    import unary_pkg::*;

    localparam int FL = 16;
    localparam int VW = val_w(FL);
    localparam int MAXF = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic          load_ready;
    logic [VW-1:0] a_value;
    logic [VW-1:0] b_value;
    logic          hold;
    logic          a_bit;
    logic          b_bit;
    logic          en_out;
    logic          frame_last;
    logic          sat;
    logic          busy;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    unary_stream_gen #(
        .FRAME_LEN(FL),
        .VAL_W    (VW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .a_value   (a_value),
        .b_value   (b_value),
        .hold      (hold),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .en_out    (en_out),
        .frame_last(frame_last),
        .sat       (sat),
        .busy      (busy)
    );

    // Stream capture: bit k of the stream lands in word k/FL, bit k%FL.
    int ncnt = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int sat_cnt = 0;
    int stray = 0;
    logic [FL-1:0] aw [MAXF];
    logic [FL-1:0] bw [MAXF];
    logic [FL-1:0] lw [MAXF];

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (en_out) begin
            if (ncnt < MAXF * FL) begin
                aw[ncnt / FL][ncnt % FL] = a_bit;
                bw[ncnt / FL][ncnt % FL] = b_bit;
                lw[ncnt / FL][ncnt % FL] = frame_last;
            end
            if (ncnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            ncnt++;
        end else if (a_bit || b_bit || frame_last) begin
            stray++;
        end
        if (sat) sat_cnt++;
    end

    function automatic logic [FL-1:0] exp_word(input int v);
        logic [63:0] t;
        int n;
        n = (v > FL) ? FL : v;
        t = (64'd1 << n) - 64'd1;
        return t[FL-1:0];
    endfunction

    task automatic clear_mon();
        ncnt = 0;
        sat_cnt = 0;
        stray = 0;
        for (int f = 0; f < MAXF; f++) begin
            aw[f] = '0;
            bw[f] = '0;
            lw[f] = '0;
        end
    endtask

    // Returns at the negedge just after the accepting edge.
    task automatic do_load(input int a, input int b);
        int t;
        t = 0;
        @(negedge clk);
        while (!load_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!load_ready) begin
            compared++;
            mismatched++;
            $display("FAIL load_wait: load_ready=%0b want 1", load_ready);
        end
        load_valid = 1'b1;
        a_value = VW'(a);
        b_value = VW'(b);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((busy || en_out) && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (busy || en_out) begin
            compared++;
            mismatched++;
            $display("FAIL idle_timeout: busy=%0b en=%0b want 0 0", busy, en_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({a_bit, b_bit, en_out, frame_last, sat, busy, load_ready} !== 7'b0000001) begin
            mismatched++;
            $display("FAIL reset_outs: got %b want 0000001",
                     {a_bit, b_bit, en_out, frame_last, sat, busy, load_ready});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({en_out, busy, load_ready} !== 3'b001) begin
            mismatched++;
            $display("FAIL post_reset_idle: got %b want 001", {en_out, busy, load_ready});
        end
    endtask

    task automatic test_basic_frame();
        clear_mon();
        do_load(3, 16);
        compared++;
        if ({en_out, busy} !== 2'b01) begin
            mismatched++;
            $display("FAIL basic_after_accept: en/busy=%b want 01", {en_out, busy});
        end
        @(negedge clk);
        compared++;
        if (en_out !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_latency: en=%0b want 1", en_out);
        end
        wait_idle();
        compared++;
        if (ncnt != FL || last_cyc - first_cyc + 1 != FL) begin
            mismatched++;
            $display("FAIL basic_len: bits=%0d span=%0d want %0d", ncnt, last_cyc - first_cyc + 1, FL);
        end
        compared++;
        if (aw[0] !== exp_word(3) || bw[0] !== exp_word(16)) begin
            mismatched++;
            $display("FAIL basic_bits: a=%h b=%h want %h %h", aw[0], bw[0], exp_word(3), exp_word(16));
        end
        compared++;
        if (lw[0] !== 16'h8000 || stray != 0 || sat_cnt != 0) begin
            mismatched++;
            $display("FAIL basic_last: last=%h stray=%0d sat=%0d want 8000 0 0", lw[0], stray, sat_cnt);
        end
    endtask

    task automatic test_sat();
        clear_mon();
        do_load(0, 20);
        compared++;
        if (sat !== 1'b1) begin
            mismatched++;
            $display("FAIL sat_pulse: sat=%0b want 1", sat);
        end
        @(negedge clk);
        compared++;
        if (sat !== 1'b0) begin
            mismatched++;
            $display("FAIL sat_width: sat=%0b want 0", sat);
        end
        wait_idle();
        compared++;
        if (aw[0] !== 16'h0000 || bw[0] !== 16'hFFFF || sat_cnt != 1) begin
            mismatched++;
            $display("FAIL sat_frame: a=%h b=%h sat=%0d want 0000 ffff 1", aw[0], bw[0], sat_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        do_load(5, 1);
        compared++;
        if (load_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_ready_low: ready=%0b want 0", load_ready);
        end
        do_load(10, 15);
        wait_idle();
        compared++;
        if (ncnt != 2 * FL || last_cyc - first_cyc + 1 != 2 * FL) begin
            mismatched++;
            $display("FAIL b2b_contig: bits=%0d span=%0d want 32", ncnt, last_cyc - first_cyc + 1);
        end
        compared++;
        if (aw[0] !== exp_word(5) || aw[1] !== exp_word(10) ||
            bw[0] !== exp_word(1) || bw[1] !== exp_word(15)) begin
            mismatched++;
            $display("FAIL b2b_bits: a=%h,%h b=%h,%h", aw[0], aw[1], bw[0], bw[1]);
        end
        compared++;
        if (lw[0] !== 16'h8000 || lw[1] !== 16'h8000) begin
            mismatched++;
            $display("FAIL b2b_last: %h %h want 8000 8000", lw[0], lw[1]);
        end
    endtask

    task automatic test_hold();
        int t;
        clear_mon();
        do_load(12, 4);
        t = 0;
        while (ncnt != 7 && t < 100) begin
            @(negedge clk);
            t++;
        end
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (en_out !== 1'b0 || a_bit !== 1'b0) begin
                mismatched++;
                $display("FAIL hold_freeze%0d: en=%0b a=%0b want 0 0", i, en_out, a_bit);
            end
        end
        hold = 1'b0;
        wait_idle();
        compared++;
        if (ncnt != FL || last_cyc - first_cyc + 1 != FL + 4) begin
            mismatched++;
            $display("FAIL hold_len: bits=%0d span=%0d want 16 20", ncnt, last_cyc - first_cyc + 1);
        end
        compared++;
        if (aw[0] !== exp_word(12) || bw[0] !== exp_word(4) || lw[0] !== 16'h8000) begin
            mismatched++;
            $display("FAIL hold_bits: a=%h b=%h last=%h", aw[0], bw[0], lw[0]);
        end
    endtask

    task automatic test_rst_mid();
        int t;
        clear_mon();
        do_load(int'($urandom_range(1, 16)), 9);
        do_load(6, 6);
        t = 0;
        while (ncnt != 9 && t < 100) begin
            @(negedge clk);
            t++;
        end
        compared++;
        if (load_ready !== 1'b0 || en_out !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid_pre: ready=%0b en=%0b want 0 1", load_ready, en_out);
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({a_bit, b_bit, en_out, frame_last, sat, busy, load_ready} !== 7'b0000001) begin
            mismatched++;
            $display("FAIL rstmid_outs: got %b want 0000001",
                     {a_bit, b_bit, en_out, frame_last, sat, busy, load_ready});
        end
        rst = 1'b0;
        clear_mon();
        repeat (40) @(negedge clk);
        compared++;
        if (ncnt != 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid_quiet: bits=%0d busy=%0b want 0 0", ncnt, busy);
        end
    endtask

    task automatic test_adder();
        int sum;
        clear_mon();
        do_load(7, 6);
        wait_idle();
        sum = $countones(aw[0]) + $countones(bw[0]);
        compared++;
        if (sum != 13 || (sum > FL)) begin
            mismatched++;
            $display("FAIL adder_7_6: count=%0d carry=%0b want 13 0", sum, sum > FL);
        end
        clear_mon();
        do_load(16, 16);
        wait_idle();
        sum = $countones(aw[0]) + $countones(bw[0]);
        compared++;
        if (sum != 32 || !(sum > FL)) begin
            mismatched++;
            $display("FAIL adder_16_16: count=%0d carry=%0b want 32 1", sum, sum > FL);
        end
    endtask

    task automatic test_random();
        int va[$];
        int vb[$];
        int sent;
        int t;
        int exp_sat;
        int a;
        int b;
        clear_mon();
        sent = 0;
        t = 0;
        exp_sat = 0;
        while ((sent < 12 || busy || en_out) && t < 3000) begin
            @(negedge clk);
            t++;
            load_valid = 1'b0;
            hold = ($urandom % 4) == 0;
            if (sent < 12 && load_ready && ($urandom % 2) == 0) begin
                a = int'($urandom_range(0, 24));
                b = int'($urandom_range(0, 24));
                load_valid = 1'b1;
                a_value = VW'(a);
                b_value = VW'(b);
                va.push_back(a);
                vb.push_back(b);
                if (a > FL || b > FL) exp_sat++;
                sent++;
            end
        end
        @(negedge clk);
        load_valid = 1'b0;
        hold = 1'b0;
        wait_idle();
        compared++;
        if (ncnt != 12 * FL || sat_cnt != exp_sat || stray != 0) begin
            mismatched++;
            $display("FAIL rand_totals: bits=%0d sat=%0d stray=%0d want %0d %0d 0",
                     ncnt, sat_cnt, stray, 12 * FL, exp_sat);
        end
        for (int f = 0; f < 12 && f < va.size(); f++) begin
            compared++;
            if (aw[f] !== exp_word(va[f]) || bw[f] !== exp_word(vb[f]) || lw[f] !== 16'h8000) begin
                mismatched++;
                $display("FAIL rand_frame%0d: a=%h b=%h last=%h want %h %h 8000",
                         f, aw[f], bw[f], lw[f], exp_word(va[f]), exp_word(vb[f]));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        load_valid = 1'b0;
        hold = 1'b0;
        a_value = '0;
        b_value = '0;
        test_reset();
        test_basic_frame();
        test_sat();
        test_back_to_back();
        test_hold();
        test_rst_mid();
        test_adder();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
